assoc_cache_ctrl: RTL and testbench
===================================

// Module: assoc_cache_ctrl
// PURPOSE
//  Parametrised set-associative read cache with a valid/ready request port and a blocking miss engine.
//  Misses are fetched from the next level (L2) over a request/response handshake, filled, and returned.
//  Successor to the fixed L1 lookup block: adds configurable ways/sets/widths, reset, flush and handshakes.
//  Sits between the CPU load port and the L2 cache.
// PARAMETERS
//  ADDR_W      11  byte-address width
//  DATA_W      32  data word width; one word per line
//  OFFSET_W    2   byte-offset bits; ignored for lookup
//  NUM_SETS    16  number of sets; power of 2, >=2
//  WAYS        2   associativity; 1, 2 or 4
//  REPL        0   replacement policy: 0 = LRU, 1 = LFSR pseudo-random
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  req_valid     in   1       CPU read request
//  req_ready     out  1       high only in IDLE with no flush pending
//  req_addr      in   ADDR_W  request byte address
//  resp_valid    out  1       one-cycle pulse; no backpressure
//  resp_hit      out  1       1 = served from cache, 0 = served by fill; valid with resp_valid
//  resp_data     out  DATA_W  returned word; valid with resp_valid
//  l2_req_valid  out  1       miss fetch request
//  l2_req_ready  in   1       L2 accepts request
//  l2_req_addr   out  ADDR_W  miss address, offset bits forced to 0
//  l2_resp_valid in   1       fill data strobe
//  l2_resp_data  in   DATA_W  fill word
//  flush         in   1       invalidate all lines (level)
// BEHAVIOUR
//  Reset:
//   - All outputs are 0 and the FSM is in IDLE.
//   - All valid bits and LRU ages are 0; LFSR = 8'hA5.
//  Address split:
//   - index = addr[OFFSET_W +: log2(NUM_SETS)].
//   - tag = all remaining upper bits.
//  FSM states:
//   - IDLE: a request is accepted when req_valid && req_ready. The address is latched and the state moves to LOOKUP.
//   - LOOKUP: tag compare across all ways. On a hit, resp_valid=1 and resp_hit=1, the LRU is updated and the state returns to IDLE.
//     Hit latency is 1 cycle after acceptance. On a miss, the state moves to MREQ.
//   - MREQ: l2_req_valid is held high and l2_req_addr is held stable until l2_req_ready; then the state moves to MWAIT.
//   - MWAIT: on l2_resp_valid, the victim way is written (valid, tag, data).
//     In the same cycle resp_valid=1, resp_hit=0, resp_data=l2_resp_data, the LRU is updated and the state returns to IDLE.
//  Victim selection:
//   - The lowest-index invalid way is used first.
//   - Otherwise REPL=0 uses the way with age 0.
//   - Otherwise REPL=1 uses LFSR[log2(WAYS)-1:0].
//  LFSR: x^8+x^6+x^5+x^4+1, advances every cycle.
//  LRU ages:
//   - Each age is log2(WAYS) bits.
//   - On access, ages greater than the accessed way's old age are decremented, and the accessed way is set to WAYS-1.
//   - Ages stay a permutation of 0..WAYS-1.
//  WAYS=1: victim is always way 0; no LRU state is needed.
//  Boundaries:
//   - Single outstanding request; req_ready=0 outside IDLE.
//   - flush in IDLE clears all valid bits and LRU ages in 1 cycle. flush and req_valid in the same IDLE cycle: flush wins and req_ready=0.
//   - flush outside IDLE is latched as pending and executed on the first IDLE cycle. The in-flight miss still fills and responds.
//   - l2_resp_valid outside MWAIT is ignored. l2_resp_valid in the same cycle as the l2_req handshake is ignored; the response must come later.
//   - rst_n low mid-miss immediately drops l2_req_valid. Any later L2 response is discarded.
// CONFIGURATION
//  CACHE_STATS_EN defined:
//   - Adds output ports stat_hits[31:0] and stat_misses[31:0].
//   - They increment on the LOOKUP hit and miss decisions, saturate at 32'hFFFFFFFF, and clear on reset and on flush.
//  CACHE_STATS_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package cache_pkg: FSM state encodings (IDLE, LOOKUP, MREQ, MWAIT), REPL_LRU/REPL_RAND constants, clog2 function,
//  LFSR seed and taps.
//  Sub-module cache_repl_sel: per-set LRU ages plus LFSR, with a victim-select output and an update input
//  (set, way, strobe); flush clear.
//  Tag/data/valid arrays and the FSM stay in this module.
// TESTING
//  1 Cold miss: read 0x104. Response: l2_req_addr=0x104, L2 returns 0xDEADBEEF, resp_hit=0, resp_data=0xDEADBEEF.
//    Re-read 0x104: resp_hit=1 and resp_valid 1 cycle after acceptance.
//  2 LRU, WAYS=2: fill tags A and B into set 1, read A, then miss on C in set 1. Response: B is evicted; read A -> hit, read B -> miss.
//  3 L2 stall: hold l2_req_ready=0 for 5 cycles. Response: l2_req_valid and l2_req_addr are stable, and req_ready stays 0 throughout.
//  4 Flush during MWAIT: the miss completes with resp_hit=0. Next IDLE cycle: all lines are invalid; re-read -> miss.
//  5 Reset mid-MREQ: rst_n pulsed low. Response: all outputs 0 asynchronously, a stale l2_resp_valid is ignored, and the previous hit address now misses.
//  6 CACHE_STATS_EN: 3 hits and 2 misses give stat_hits=3 and stat_misses=2; flush clears both to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative read cache: FSM state
// encodings, replacement policy selectors, the clog2 helper and the
// pseudo-random generator seed/taps.
package cache_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_MREQ   = 2'd2;
    localparam logic [1:0] S_MWAIT  = 2'd3;

    localparam int REPL_LRU  = 0;
    localparam int REPL_RAND = 1;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left; feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// CPU load port and L2 fetch port of the read cache, bundled together.
// slave: the cache side. master: the CPU/L2 environment side.
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_resp_valid;
    logic [DATA_W-1:0] l2_resp_data;

    modport slave (
        input  req_valid, req_addr, l2_req_ready, l2_resp_valid, l2_resp_data,
        output req_ready, resp_valid, resp_hit, resp_data, l2_req_valid, l2_req_addr
    );

    modport master (
        output req_valid, req_addr, l2_req_ready, l2_resp_valid, l2_resp_data,
        input  req_ready, resp_valid, resp_hit, resp_data, l2_req_valid, l2_req_addr
    );
endinterface

// File: rtl/cache_repl_sel.sv
// Replacement state for the read cache: per-set LRU ages plus a free-running
// 8-bit LFSR. Produces the fill victim for one set and takes an access update
// (set, way, strobe). A flush returns every age to 0.
module cache_repl_sel
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int WAYS     = 2,
    parameter int REPL     = REPL_LRU,
    localparam int IDX_W   = clog2(NUM_SETS),
    localparam int AW      = (WAYS > 1) ? clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] set_i,
    input  logic [WAYS-1:0]  valid_i,
    input  logic             upd_i,
    input  logic [IDX_W-1:0] upd_set_i,
    input  logic [AW-1:0]    upd_way_i,
    output logic [AW-1:0]    victim_o
);

    logic [7:0] lfsr_q;

    // LFSR advances every cycle, independent of traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    if (WAYS > 1) begin : g_assoc
        logic [AW-1:0] age_q [NUM_SETS][WAYS];
        logic [AW-1:0] old_age;

        assign old_age = age_q[upd_set_i][upd_way_i];

        // Accessed way becomes youngest; ways younger than it age by one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end else if (flush_i) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end else if (upd_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AW'(w) == upd_way_i)
                        age_q[upd_set_i][w] <= AW'(WAYS - 1);
                    else if (age_q[upd_set_i][w] > old_age)
                        age_q[upd_set_i][w] <= age_q[upd_set_i][w] - AW'(1);
                end
            end
        end

        // Lowest invalid way first, then the policy's choice; the LFSR also
        // backs up LRU should the ages ever not contain a zero
        always_comb begin
            logic found;
            found    = 1'b0;
            victim_o = lfsr_q[AW-1:0];
            for (int w = 0; w < WAYS; w++) begin
                if (!found && !valid_i[w]) begin
                    victim_o = AW'(w);
                    found    = 1'b1;
                end
            end
            if (!found && REPL == REPL_LRU) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (!found && age_q[set_i][w] == '0) begin
                        victim_o = AW'(w);
                        found    = 1'b1;
                    end
                end
            end
        end
    end else begin : g_direct
        assign victim_o = '0;
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Set-associative read cache with a blocking miss engine.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters
// (stat_hits/stat_misses), cleared on reset and on flush.
//
// state  | meaning
// IDLE   | ready for a request; executes a flush (live or pending) instead
// LOOKUP | tag compare on the latched address; hit responds here
// MREQ   | holding the line fetch request towards L2
// MWAIT  | waiting for the L2 fill word; fill and response in one cycle
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int NUM_SETS = 16,
    parameter int WAYS     = 2,
    parameter int REPL     = REPL_LRU
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    assoc_cache_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_misses
`endif
);

    localparam int IDX_W  = clog2(NUM_SETS);
    localparam int AW     = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam int TAG_W  = LINE_W - IDX_W;

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              flush_pend_q, flush_pend_d;
    logic              run_q;

    logic [WAYS-1:0]   valid_q [NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS][WAYS];
    logic [DATA_W-1:0] data_q  [NUM_SETS][WAYS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_cur;
    logic              hit;
    logic [AW-1:0]     hit_way;
    logic [DATA_W-1:0] hit_data;
    logic [AW-1:0]     victim;
    logic              accept, do_flush, fill, lookup_hit, lookup_miss;
    logic              unused_offset;

    assign unused_offset = ^bus.req_addr[OFFSET_W-1:0];

    assign idx     = line_q[IDX_W-1:0];
    assign tag_cur = line_q[LINE_W-1:IDX_W];

    // Tag compare across all ways of the latched set
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag_cur) begin
                hit      = 1'b1;
                hit_way  = AW'(w);
                hit_data = data_q[idx][w];
            end
        end
    end

    assign do_flush    = (state_q == S_IDLE) && (flush || flush_pend_q);
    assign accept      = bus.req_valid && bus.req_ready;
    assign lookup_hit  = (state_q == S_LOOKUP) && hit;
    assign lookup_miss = (state_q == S_LOOKUP) && !hit;
    assign fill        = (state_q == S_MWAIT) && bus.l2_resp_valid;

    // run_q keeps req_ready low while reset is asserted
    assign bus.req_ready    = run_q && (state_q == S_IDLE) && !flush && !flush_pend_q;
    assign bus.resp_valid   = lookup_hit || fill;
    assign bus.resp_hit     = lookup_hit;
    assign bus.resp_data    = lookup_hit ? hit_data : (fill ? bus.l2_resp_data : '0);
    assign bus.l2_req_valid = (state_q == S_MREQ);
    assign bus.l2_req_addr  = (state_q == S_MREQ) ? {line_q, {OFFSET_W{1'b0}}} : '0;

    cache_repl_sel #(
        .NUM_SETS (NUM_SETS),
        .WAYS     (WAYS),
        .REPL     (REPL)
    ) u_repl (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (do_flush),
        .set_i     (idx),
        .valid_i   (valid_q[idx]),
        .upd_i     (lookup_hit || fill),
        .upd_set_i (idx),
        .upd_way_i (lookup_hit ? hit_way : victim),
        .victim_o  (victim)
    );

    // Next-state, address latch and flush-pending bookkeeping
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        if (do_flush)
            flush_pend_d = 1'b0;
        else if (flush && state_q != S_IDLE)
            flush_pend_d = 1'b1;
        case (state_q)
            S_IDLE:   if (accept) begin
                          state_d = S_LOOKUP;
                          line_d  = bus.req_addr[ADDR_W-1:OFFSET_W];
                      end
            S_LOOKUP: state_d = hit ? S_IDLE : S_MREQ;
            S_MREQ:   if (bus.l2_req_ready) state_d = S_MWAIT;
            S_MWAIT:  if (bus.l2_resp_valid) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            run_q        <= 1'b1;
        end
    end

    // Valid bits: cleared by reset/flush, set by a fill of the victim way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (do_flush) begin
            for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
        end else if (fill) begin
            valid_q[idx][victim] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless while the valid bit is 0
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[idx][victim]  <= tag_cur;
            data_q[idx][victim] <= bus.l2_resp_data;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    // Saturating lookup statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (do_flush) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (lookup_hit && hits_q != '1)    hits_q   <= hits_q + 32'd1;
            if (lookup_miss && misses_q != '1) misses_q <= misses_q + 32'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed self-checking bench for assoc_cache_ctrl (default parameters:
// 11-bit address, 16 sets, 2 ways, LRU). Build with CACHE_STATS_EN to
// also exercise the statistics counters.
module tb_assoc_cache_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    assoc_cache_ctrl_if #(.ADDR_W(11), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    assoc_cache_ctrl #(
        .ADDR_W(11), .DATA_W(32), .OFFSET_W(2), .NUM_SETS(16), .WAYS(2), .REPL(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tg, obs, exp);
        end
    endtask

    // One CPU read. On a miss the L2 side is played with an optional request
    // stall and an optional flush pulse while waiting for the fill.
    task automatic cpu_read(input string tg, input logic [10:0] a, input logic [31:0] l2d,
                            input logic exp_hit, input logic [31:0] exp_d,
                            input int stall, input logic flush_in_wait);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        #1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tg, "_accept"}, {31'd0, bus.req_ready}, 32'd1);
        check({tg, "_idle_resp"}, {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check({tg, "_lookup_valid"}, {31'd0, bus.resp_valid}, {31'd0, exp_hit});
        check({tg, "_lookup_ready"}, {31'd0, bus.req_ready}, 32'd0);
        if (exp_hit) begin
            check({tg, "_hit_flag"}, {31'd0, bus.resp_hit}, 32'd1);
            check({tg, "_hit_data"}, bus.resp_data, exp_d);
        end else begin
            @(negedge clk); #1;
            for (int i = 0; i < stall; i++) begin
                check({tg, "_stall_l2v"}, {31'd0, bus.l2_req_valid}, 32'd1);
                check({tg, "_stall_addr"}, {21'd0, bus.l2_req_addr}, {21'd0, a & 11'h7FC});
                check({tg, "_stall_ready"}, {31'd0, bus.req_ready}, 32'd0);
                @(negedge clk); #1;
            end
            check({tg, "_l2v"}, {31'd0, bus.l2_req_valid}, 32'd1);
            check({tg, "_l2addr"}, {21'd0, bus.l2_req_addr}, {21'd0, a & 11'h7FC});
            // a response in the handshake cycle must be ignored
            bus.l2_req_ready  = 1'b1;
            bus.l2_resp_valid = 1'b1;
            bus.l2_resp_data  = ~l2d;
            @(negedge clk);
            bus.l2_req_ready  = 1'b0;
            bus.l2_resp_valid = 1'b0;
            #1;
            check({tg, "_wait_l2v"}, {31'd0, bus.l2_req_valid}, 32'd0);
            check({tg, "_wait_resp"}, {31'd0, bus.resp_valid}, 32'd0);
            if (flush_in_wait) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            bus.l2_resp_valid = 1'b1;
            bus.l2_resp_data  = l2d;
            #1;
            check({tg, "_fill_valid"}, {31'd0, bus.resp_valid}, 32'd1);
            check({tg, "_fill_hit"}, {31'd0, bus.resp_hit}, 32'd0);
            check({tg, "_fill_data"}, bus.resp_data, exp_d);
            @(negedge clk);
            bus.l2_resp_valid = 1'b0;
            #1;
            check({tg, "_post_ready"}, {31'd0, bus.req_ready}, {31'd0, !flush_in_wait});
        end
    endtask

    // Flush in IDLE with a simultaneous request: flush wins, nothing accepted
    task automatic flush_idle(input string tg);
        @(negedge clk);
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 11'h104;
        #1;
        check({tg, "_flush_ready"}, {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check({tg, "_after_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tg, "_after_resp"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.l2_req_ready  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_data  = '0;

        #2;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_hit", {31'd0, bus.resp_hit}, 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_l2_valid", {31'd0, bus.l2_req_valid}, 32'd0);
        check("rst_l2_addr", {21'd0, bus.l2_req_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // cold miss then hit on 0x104 (set 1, tag 4)
        cpu_read("t1_cold", 11'h104, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        cpu_read("t1_hit",  11'h104, 32'h0,        1'b1, 32'hDEADBEEF, 0, 1'b0);

        // LRU in set 1: A=tag1 (offset bits set), B=tag2, C=tag3
        flush_idle("t2");
        cpu_read("t2_fillA", 11'h045, 32'hAAAA0001, 1'b0, 32'hAAAA0001, 0, 1'b0);
        cpu_read("t2_fillB", 11'h084, 32'hBBBB0002, 1'b0, 32'hBBBB0002, 0, 1'b0);
        cpu_read("t2_hitA",  11'h044, 32'h0,        1'b1, 32'hAAAA0001, 0, 1'b0);
        cpu_read("t2_missC", 11'h0C4, 32'hCCCC0003, 1'b0, 32'hCCCC0003, 0, 1'b0);
        cpu_read("t2_hitA2", 11'h046, 32'h0,        1'b1, 32'hAAAA0001, 0, 1'b0);
        cpu_read("t2_missB", 11'h084, 32'hBBBB0012, 1'b0, 32'hBBBB0012, 0, 1'b0);

        // L2 request stall for 5 cycles
        cpu_read("t3_stall", 11'h20B, 32'h12345678, 1'b0, 32'h12345678, 5, 1'b0);

        // flush arriving in MWAIT: miss completes, then everything invalid
        cpu_read("t4_flushwait", 11'h300, 32'h30303030, 1'b0, 32'h30303030, 0, 1'b1);
        cpu_read("t4_reread",    11'h300, 32'h31313131, 1'b0, 32'h31313131, 0, 1'b0);
        cpu_read("t4_oldline",   11'h20B, 32'h22222222, 1'b0, 32'h22222222, 0, 1'b0);

        // reset in the middle of a miss request
        cpu_read("t5_hitX", 11'h300, 32'h0, 1'b1, 32'h31313131, 0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 11'h3C8;
        #1;
        check("t5_accept", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk); #1;
        check("t5_mreq_l2v", {31'd0, bus.l2_req_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_l2v", {31'd0, bus.l2_req_valid}, 32'd0);
        check("t5_rst_l2addr", {21'd0, bus.l2_req_addr}, 32'd0);
        check("t5_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check("t5_rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.l2_resp_valid = 1'b1;
        bus.l2_resp_data  = 32'hBAD0BAD0;
        #1;
        check("t5_stale_resp", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        bus.l2_resp_valid = 1'b0;
        #1;
        check("t5_stale_resp2", {31'd0, bus.resp_valid}, 32'd0);
        check("t5_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        cpu_read("t5_missX", 11'h300, 32'h33333333, 1'b0, 32'h33333333, 0, 1'b0);

`ifdef CACHE_STATS_EN
        flush_idle("t6");
        check("t6_hits0", stat_hits, 32'd0);
        check("t6_miss0", stat_misses, 32'd0);
        cpu_read("t6_m1", 11'h010, 32'h00000010, 1'b0, 32'h00000010, 0, 1'b0);
        cpu_read("t6_m2", 11'h020, 32'h00000020, 1'b0, 32'h00000020, 0, 1'b0);
        cpu_read("t6_h1", 11'h010, 32'h0, 1'b1, 32'h00000010, 0, 1'b0);
        cpu_read("t6_h2", 11'h011, 32'h0, 1'b1, 32'h00000010, 0, 1'b0);
        cpu_read("t6_h3", 11'h020, 32'h0, 1'b1, 32'h00000020, 0, 1'b0);
        @(negedge clk); #1;
        check("t6_hits3", stat_hits, 32'd3);
        check("t6_miss2", stat_misses, 32'd2);
        flush_idle("t6_clr");
        check("t6_hits_clr", stat_hits, 32'd0);
        check("t6_miss_clr", stat_misses, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
